// File: rtl/ahb_sram_slave.sv
// AHB responder terminating the bus in a word-addressed on-chip memory with configurable wait states.
// Optional build macro AHB_SRAM_RAND_WAIT_EN: per-transfer wait count drawn from a 16-bit LFSR.
module ahb_sram_slave #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_BYTES   = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic                  hclk,
    input  logic                  hresetn,
    input  logic                  hsel,
    input  logic [ADDR_WIDTH-1:0] haddr,
    input  logic [2:0]            hburst,
    input  logic                  hmastlock,
    input  logic [6:0]            hprot,
    input  logic [2:0]            hsize,
    input  logic                  hnonsec,
    input  logic                  hexcl,
    input  logic [3:0]            hmaster,
    input  logic [1:0]            htrans,
    input  logic [DATA_WIDTH-1:0] hwdata,
    input  logic                  hwrite,
    output logic [DATA_WIDTH-1:0] hrdata,
    output logic                  hready,
    output logic                  hresp,
    output logic                  hexokay
);
    localparam int NB     = DATA_WIDTH / 8;
    localparam int OFF_W  = $clog2(NB);
    localparam int MEM_AW = $clog2(MEM_BYTES);
    localparam int IDX_W  = MEM_AW - OFF_W;
    localparam int WORDS  = MEM_BYTES / NB;
    localparam logic [2:0]            SIZE_MAX  = 3'(OFF_W);
    localparam logic [ADDR_WIDTH-1:0] MEM_LIMIT = ADDR_WIDTH'(MEM_BYTES);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_DATA = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } state_t;

    function automatic logic [NB-1:0] lane_mask(input logic [2:0] size, input logic [OFF_W-1:0] off);
        logic [NB-1:0] m;
        int span;
        span = 32'sd1 << size;
        for (int i = 0; i < NB; i++) begin
            m[i] = (i >= int'(off)) && (i < int'(off) + span);
        end
        return m;
    endfunction

    function automatic logic is_aligned(input logic [2:0] size, input logic [OFF_W-1:0] off);
        logic [OFF_W-1:0] m;
        m = OFF_W'((32'd1 << size) - 32'd1);
        return (off & m) == '0;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] merge_lanes(input logic [DATA_WIDTH-1:0] old_w,
                                                          input logic [DATA_WIDTH-1:0] new_w,
                                                          input logic [NB-1:0]         m);
        logic [DATA_WIDTH-1:0] r;
        for (int i = 0; i < NB; i++) begin
            r[8*i +: 8] = m[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
        end
        return r;
    endfunction

    logic [DATA_WIDTH-1:0] mem [WORDS];

    state_t                state_r, state_nxt_s;
    logic [3:0]            count_r, count_nxt_s;
    logic                  hready_r, hready_nxt_s;
    logic                  hresp_r, hresp_nxt_s;
    logic [DATA_WIDTH-1:0] hrdata_r, hrdata_nxt_s;
    logic                  active_r, active_nxt_s;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic [2:0]            size_r;
    logic                  write_r;

    logic                  accept_s, legal_s, commit_s, rd_en_s;
    logic [3:0]            wait_sel_s;
    logic [IDX_W-1:0]      rd_idx_s, wr_idx_s;
    logic [NB-1:0]         wr_mask_s;
    logic [DATA_WIDTH-1:0] rd_word_s;

    assign accept_s  = hready_r && hsel && htrans[1];
    assign legal_s   = (haddr < MEM_LIMIT) && (hsize <= SIZE_MAX) && is_aligned(hsize, haddr[OFF_W-1:0]);
    assign commit_s  = active_r && write_r;
    assign wr_idx_s  = addr_r[MEM_AW-1:OFF_W];
    assign wr_mask_s = lane_mask(size_r, addr_r[OFF_W-1:0]);

`ifdef AHB_SRAM_RAND_WAIT_EN
    logic [15:0] lfsr_r;
    assign wait_sel_s = 4'(32'(lfsr_r[3:0]) % 32'(WAIT_STATES + 1));

    // Fibonacci LFSR stepped once per legal accepted transfer.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            lfsr_r <= 16'hACE1;
        end else if (accept_s && legal_s) begin
            lfsr_r <= {lfsr_r[14:0], lfsr_r[15] ^ lfsr_r[13] ^ lfsr_r[12] ^ lfsr_r[10]};
        end
    end
`else
    assign wait_sel_s = 4'(WAIT_STATES);
`endif

    // Read data forwards a write committing on the same edge so back-to-back write/read sees new data.
    always_comb begin
        rd_word_s = mem[rd_idx_s];
        if (commit_s && (wr_idx_s == rd_idx_s)) begin
            rd_word_s = merge_lanes(mem[rd_idx_s], hwdata, wr_mask_s);
        end else begin
            rd_word_s = mem[rd_idx_s];
        end
    end

    // Next-state and next-output decode for the data-phase sequencer.
    always_comb begin
        state_nxt_s  = state_r;
        count_nxt_s  = count_r;
        hready_nxt_s = 1'b1;
        hresp_nxt_s  = 1'b0;
        active_nxt_s = 1'b0;
        rd_en_s      = 1'b0;
        rd_idx_s     = haddr[MEM_AW-1:OFF_W];
        case (state_r)
            ST_IDLE, ST_DATA, ST_ERR2: begin
                if (accept_s && !legal_s) begin
                    state_nxt_s  = ST_ERR1;
                    hready_nxt_s = 1'b0;
                    hresp_nxt_s  = 1'b1;
                end else if (accept_s && (wait_sel_s == 4'd0)) begin
                    state_nxt_s  = ST_IDLE;
                    active_nxt_s = 1'b1;
                    rd_en_s      = !hwrite;
                end else if (accept_s) begin
                    state_nxt_s  = ST_WAIT;
                    count_nxt_s  = wait_sel_s;
                    hready_nxt_s = 1'b0;
                end else begin
                    state_nxt_s  = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (count_r <= 4'd1) begin
                    state_nxt_s  = ST_DATA;
                    count_nxt_s  = 4'd0;
                    active_nxt_s = 1'b1;
                    rd_en_s      = !write_r;
                    rd_idx_s     = addr_r[MEM_AW-1:OFF_W];
                end else begin
                    count_nxt_s  = count_r - 4'd1;
                    hready_nxt_s = 1'b0;
                end
            end
            ST_ERR1: begin
                state_nxt_s = ST_ERR2;
                hresp_nxt_s = 1'b1;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
        hrdata_nxt_s = rd_en_s ? rd_word_s : '0;
    end

    // Sequencer state, registered bus outputs and captured address phase.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_r  <= ST_IDLE;
            count_r  <= 4'd0;
            hready_r <= 1'b1;
            hresp_r  <= 1'b0;
            hrdata_r <= '0;
            active_r <= 1'b0;
            addr_r   <= '0;
            size_r   <= 3'd0;
            write_r  <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            count_r  <= count_nxt_s;
            hready_r <= hready_nxt_s;
            hresp_r  <= hresp_nxt_s;
            hrdata_r <= hrdata_nxt_s;
            active_r <= active_nxt_s;
            if (accept_s) begin
                addr_r  <= haddr;
                size_r  <= hsize;
                write_r <= hwrite;
            end
        end
    end

    // Memory array: byte-lane write at the end of a legal write's final data cycle.
    always_ff @(posedge hclk) begin
        if (commit_s) begin
            mem[wr_idx_s] <= merge_lanes(mem[wr_idx_s], hwdata, wr_mask_s);
        end
    end

    assign hready  = hready_r;
    assign hresp   = hresp_r;
    assign hrdata  = hrdata_r;
    assign hexokay = 1'b0;

    logic unused_s;
    assign unused_s = ^{hburst, hmastlock, hprot, hnonsec, hexcl, hmaster, htrans[0],
                        addr_r[ADDR_WIDTH-1:MEM_AW]};
endmodule

// File: tb/tb_ahb_sram_slave.sv
// Self-checking bench for ahb_sram_slave: three instances (0, 3 and 5 wait states) driven by a pipelined master.
`timescale 1ns/1ps
module tb_ahb_sram_slave;
    localparam int NDUT = 3;
    localparam int NV   = 31;
    localparam logic [1:0] NS = 2'd2;
    localparam logic [1:0] SQ = 2'd3;

    typedef struct {
        int          dut;
        logic [1:0]  trans;
        logic [31:0] addr;
        logic [2:0]  size;
        logic        wr;
        logic [31:0] wdata;
        logic        resp;
        logic [31:0] rdata;
        int          cyc;
    } vec_t;

    logic        hclk = 1'b0;
    logic        hresetn;
    logic [31:0] haddr;
    logic [2:0]  hsize;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [31:0] hwdata;
    logic        hsel_v    [NDUT];
    logic        hready_v  [NDUT];
    logic        hresp_v   [NDUT];
    logic        hexokay_v [NDUT];
    logic [31:0] hrdata_v  [NDUT];

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cur      = 0;
    int   tot_cyc  = 0;
    vec_t vecs [NV];
    vec_t req_q [$];
    vec_t sb_q [$];

    always #5 hclk = ~hclk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        ahb_sram_slave #(
            .ADDR_WIDTH (32),
            .DATA_WIDTH (32),
            .MEM_BYTES  (1024),
            .WAIT_STATES((g == 0) ? 0 : ((g == 1) ? 3 : 5))
        ) u_dut (
            .hclk     (hclk),
            .hresetn  (hresetn),
            .hsel     (hsel_v[g]),
            .haddr    (haddr),
            .hburst   (3'd0),
            .hmastlock(1'b0),
            .hprot    (7'd0),
            .hsize    (hsize),
            .hnonsec  (1'b0),
            .hexcl    (1'b0),
            .hmaster  (4'd0),
            .htrans   (htrans),
            .hwdata   (hwdata),
            .hwrite   (hwrite),
            .hrdata   (hrdata_v[g]),
            .hready   (hready_v[g]),
            .hresp    (hresp_v[g]),
            .hexokay  (hexokay_v[g])
        );
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        for (int i = 0; i < NDUT; i++) hsel_v[i] = 1'b0;
        htrans = 2'd0;
        hwrite = 1'b0;
    endtask

    task automatic drive_addr(input vec_t v);
        for (int i = 0; i < NDUT; i++) hsel_v[i] = (i == v.dut);
        htrans = v.trans;
        haddr  = v.addr;
        hsize  = v.size;
        hwrite = v.wr;
    endtask

    // Pipelined master: issues queued transfers, scoreboard compares each data phase as it completes.
    task automatic run(input int budget);
        int   n;
        bit   dp_v;
        int   dp_cyc;
        vec_t e;
        n      = 0;
        dp_v   = 1'b0;
        dp_cyc = 0;
        while (((req_q.size() != 0) || dp_v) && (n < budget)) begin
            @(negedge hclk);
            n++;
            if (dp_v) begin
                dp_cyc++;
                hwdata = sb_q[0].wdata;
                if (!hready_v[cur]) begin
                    check("wait_resp", 32'(hresp_v[cur]), 32'(sb_q[0].resp));
                    check("wait_rdata_zero", hrdata_v[cur], 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check($sformatf("resp@%0h", e.addr), 32'(hresp_v[cur]), 32'(e.resp));
                    if (!e.wr) check($sformatf("rdata@%0h", e.addr), hrdata_v[cur], e.rdata);
                    check($sformatf("cycles@%0h", e.addr), 32'(dp_cyc), 32'(e.cyc));
                    tot_cyc += dp_cyc;
                    dp_v = 1'b0;
                end
            end else begin
                check("idle_ready", 32'(hready_v[cur]), 32'd1);
                check("idle_resp", 32'(hresp_v[cur]), 32'd0);
            end
            if (hready_v[cur]) begin
                if (req_q.size() != 0) begin
                    e = req_q.pop_front();
                    drive_addr(e);
                    sb_q.push_back(e);
                    dp_v   = 1'b1;
                    dp_cyc = 0;
                end else begin
                    drive_idle();
                end
            end
        end
        if (n >= budget) begin
            n_fail++;
            $display("FAIL run_timeout: got %0d cycles required completion within %0d", n, budget);
            req_q.delete();
            sb_q.delete();
        end
        drive_idle();
    endtask

    task automatic run_rows(input int lo, input int hi);
        cur     = vecs[lo].dut;
        tot_cyc = 0;
        for (int i = lo; i <= hi; i++) req_q.push_back(vecs[i]);
        run(400);
    endtask

    initial begin
        // dut, trans, addr, size, wr, wdata, resp, rdata, data-phase cycles
        vecs[0]  = '{0, NS, 32'h010, 3'd2, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0, 1};
        vecs[1]  = '{0, NS, 32'h010, 3'd2, 1'b0, 32'h0, 1'b0, 32'hDEADBEEF, 1};
        vecs[2]  = '{0, NS, 32'h020, 3'd2, 1'b1, 32'h11223344, 1'b0, 32'h0, 1};
        vecs[3]  = '{0, NS, 32'h021, 3'd0, 1'b1, 32'h0000AA00, 1'b0, 32'h0, 1};
        vecs[4]  = '{0, NS, 32'h020, 3'd2, 1'b0, 32'h0, 1'b0, 32'h1122AA44, 1};
        vecs[5]  = '{0, NS, 32'h022, 3'd1, 1'b1, 32'hBEEF0000, 1'b0, 32'h0, 1};
        vecs[6]  = '{0, NS, 32'h020, 3'd2, 1'b0, 32'h0, 1'b0, 32'hBEEFAA44, 1};
        vecs[7]  = '{0, NS, 32'h023, 3'd0, 1'b0, 32'h0, 1'b0, 32'hBEEFAA44, 1};
        vecs[8]  = '{0, NS, 32'h000, 3'd2, 1'b1, 32'hCAFEF00D, 1'b0, 32'h0, 1};
        vecs[9]  = '{0, NS, 32'h400, 3'd2, 1'b0, 32'h0, 1'b1, 32'h0, 2};
        vecs[10] = '{0, NS, 32'h002, 3'd2, 1'b1, 32'hFFFFFFFF, 1'b1, 32'h0, 2};
        vecs[11] = '{0, NS, 32'h021, 3'd1, 1'b1, 32'hFFFFFFFF, 1'b1, 32'h0, 2};
        vecs[12] = '{0, NS, 32'h008, 3'd3, 1'b1, 32'hFFFFFFFF, 1'b1, 32'h0, 2};
        vecs[13] = '{0, NS, 32'h000, 3'd2, 1'b0, 32'h0, 1'b0, 32'hCAFEF00D, 1};
        vecs[14] = '{0, NS, 32'h020, 3'd2, 1'b0, 32'h0, 1'b0, 32'hBEEFAA44, 1};
        vecs[15] = '{0, NS, 32'h3FC, 3'd2, 1'b1, 32'h55AA55AA, 1'b0, 32'h0, 1};
        vecs[16] = '{0, NS, 32'h3FC, 3'd2, 1'b0, 32'h0, 1'b0, 32'h55AA55AA, 1};
        vecs[17] = '{1, NS, 32'h040, 3'd2, 1'b1, 32'h01020304, 1'b0, 32'h0, 4};
        vecs[18] = '{1, NS, 32'h040, 3'd2, 1'b0, 32'h0, 1'b0, 32'h01020304, 4};
        vecs[19] = '{1, NS, 32'h050, 3'd2, 1'b1, 32'hA0A0A0A0, 1'b0, 32'h0, 4};
        vecs[20] = '{1, SQ, 32'h054, 3'd2, 1'b1, 32'hA1A1A1A1, 1'b0, 32'h0, 4};
        vecs[21] = '{1, SQ, 32'h058, 3'd2, 1'b1, 32'hA2A2A2A2, 1'b0, 32'h0, 4};
        vecs[22] = '{1, SQ, 32'h05C, 3'd2, 1'b1, 32'hA3A3A3A3, 1'b0, 32'h0, 4};
        vecs[23] = '{1, NS, 32'h050, 3'd2, 1'b0, 32'h0, 1'b0, 32'hA0A0A0A0, 4};
        vecs[24] = '{1, SQ, 32'h054, 3'd2, 1'b0, 32'h0, 1'b0, 32'hA1A1A1A1, 4};
        vecs[25] = '{1, SQ, 32'h058, 3'd2, 1'b0, 32'h0, 1'b0, 32'hA2A2A2A2, 4};
        vecs[26] = '{1, SQ, 32'h05C, 3'd2, 1'b0, 32'h0, 1'b0, 32'hA3A3A3A3, 4};
        vecs[27] = '{1, NS, 32'h400, 3'd2, 1'b0, 32'h0, 1'b1, 32'h0, 2};
        vecs[28] = '{1, NS, 32'h040, 3'd2, 1'b0, 32'h0, 1'b0, 32'h01020304, 4};
        vecs[29] = '{2, NS, 32'h030, 3'd2, 1'b1, 32'h00000000, 1'b0, 32'h0, 6};
        vecs[30] = '{2, NS, 32'h030, 3'd2, 1'b0, 32'h0, 1'b0, 32'h00000000, 6};

        hresetn = 1'b0;
        haddr   = 32'd0;
        hsize   = 3'd0;
        hwdata  = 32'd0;
        drive_idle();
        repeat (3) @(negedge hclk);
        for (int d = 0; d < NDUT; d++) begin
            check($sformatf("rst_hready%0d", d), 32'(hready_v[d]), 32'd1);
            check($sformatf("rst_hresp%0d", d), 32'(hresp_v[d]), 32'd0);
            check($sformatf("rst_hrdata%0d", d), hrdata_v[d], 32'd0);
            check($sformatf("rst_hexokay%0d", d), 32'(hexokay_v[d]), 32'd0);
        end
        hresetn = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge hclk);
            for (int d = 0; d < NDUT; d++) begin
                check("idle5_hready", 32'(hready_v[d]), 32'd1);
                check("idle5_hresp", 32'(hresp_v[d]), 32'd0);
            end
        end

        run_rows(0, 16);
        run_rows(17, 18);
        run_rows(19, 22);
        check("burst_wr_total_cycles", 32'(tot_cyc), 32'd16);
        run_rows(23, 26);
        check("burst_rd_total_cycles", 32'(tot_cyc), 32'd16);
        run_rows(27, 28);
        run_rows(29, 29);

        // Reset asserted two cycles into a five-wait-state write: the write must be dropped.
        cur = 2;
        @(negedge hclk);
        drive_addr('{2, NS, 32'h030, 3'd2, 1'b1, 32'h12345678, 1'b0, 32'h0, 6});
        @(negedge hclk);
        drive_idle();
        hwdata = 32'h12345678;
        check("midwait_w1_hready", 32'(hready_v[2]), 32'd0);
        @(negedge hclk);
        check("midwait_w2_hready", 32'(hready_v[2]), 32'd0);
        hresetn = 1'b0;
        #1;
        check("midwait_rst_hready", 32'(hready_v[2]), 32'd1);
        check("midwait_rst_hresp", 32'(hresp_v[2]), 32'd0);
        check("midwait_rst_hrdata", hrdata_v[2], 32'd0);
        @(negedge hclk);
        hresetn = 1'b1;
        run_rows(30, 30);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog");
    end
endmodule
